// File: rtl/filt_seq_ctrl_if.sv
// filt_seq_ctrl_if: bundles every non-clock/reset signal of filt_seq_ctrl.
//   master : controller side (filt_seq_ctrl)
//   slave  : sample source, rbuf, history/coef BRAMs and FIR filter side
// Groups: sample handshake (smp_*), rbuf trigger + BRAM port (rbuf_*),
// filter control/BRAM requests (filt_*), history BRAM (xant_*),
// coefficient BRAM (coef_*), result (res_*), status (busy, err).
interface filt_seq_ctrl_if #(
  parameter int ADDR_SIZE = 5,
  parameter int DATA_SIZE = 16,
  parameter int SEL_SIZE  = 2
);
  logic                          smp_valid;
  logic [DATA_SIZE-1:0]          smp_data;
  logic                          smp_ready;
  logic [SEL_SIZE-1:0]           filt_sel;
  logic                          dc_en;
  logic                          rbuf_start;
  logic [DATA_SIZE-1:0]          rbuf_di;
  logic [ADDR_SIZE-1:0]          rbuf_addr;
  logic                          rbuf_en;
  logic                          rbuf_we;
  logic [DATA_SIZE-1:0]          rbuf_do;
  logic                          rbuf_done;
  logic                          filt_start;
  logic                          filt_ready;
  logic                          filt_done;
  logic [DATA_SIZE-1:0]          filt_result;
  logic                          filt_dcValEn;
  logic [ADDR_SIZE-1:0]          filt_xant_addr;
  logic                          filt_xant_ce;
  logic [ADDR_SIZE-1:0]          filt_xcoefs_addr;
  logic                          filt_xcoefs_ce;
  logic                          xant_en;
  logic                          xant_we;
  logic [ADDR_SIZE-1:0]          xant_addr;
  logic [DATA_SIZE-1:0]          xant_din;
  logic                          coef_en;
  logic [SEL_SIZE+ADDR_SIZE-1:0] coef_addr;
  logic                          res_valid;
  logic [DATA_SIZE-1:0]          res_data;
  logic                          busy;
  logic                          err;

  modport master (
    input  smp_valid, smp_data, filt_sel, dc_en,
           rbuf_addr, rbuf_en, rbuf_we, rbuf_do, rbuf_done,
           filt_ready, filt_done, filt_result,
           filt_xant_addr, filt_xant_ce, filt_xcoefs_addr, filt_xcoefs_ce,
    output smp_ready, rbuf_start, rbuf_di, filt_start, filt_dcValEn,
           xant_en, xant_we, xant_addr, xant_din, coef_en, coef_addr,
           res_valid, res_data, busy, err
  );

  modport slave (
    output smp_valid, smp_data, filt_sel, dc_en,
           rbuf_addr, rbuf_en, rbuf_we, rbuf_do, rbuf_done,
           filt_ready, filt_done, filt_result,
           filt_xant_addr, filt_xant_ce, filt_xcoefs_addr, filt_xcoefs_ce,
    input  smp_ready, rbuf_start, rbuf_di, filt_start, filt_dcValEn,
           xant_en, xant_we, xant_addr, xant_din, coef_en, coef_addr,
           res_valid, res_data, busy, err
  );
endinterface

// File: rtl/filt_seq_ctrl.sv
// filt_seq_ctrl: sequences one sample through ring buffer + FIR filter.
// Accepts a sample, pulses rbuf_start, waits rbuf_done, launches the filter
// (ap_start/ap_ready/ap_done) and captures its result as a 1-cycle res_valid.
// Owns the history BRAM port (rbuf during write, filter otherwise) and builds
// the coefficient address from the bank latched at sample accept.
// Ports: clk, rst_n (async active-low), bus (filt_seq_ctrl_if.master).
// Optional: define FILT_WDOG_EN for a WDOG_CYCLES watchdog with sticky err.
module filt_seq_ctrl #(
  parameter int M           = 23,
  parameter int ADDR_SIZE   = 5,
  parameter int DATA_SIZE   = 16,
  parameter int SEL_SIZE    = 2,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  filt_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, WRITE, WAIT_RBUF, START, RUN} state_t;

  state_t                state_q, state_d;
  logic                  alive_q;   // keeps smp_ready low through reset
  logic [DATA_SIZE-1:0]  di_q;
  logic [SEL_SIZE-1:0]   sel_q;
  logic                  dc_q;
  logic [DATA_SIZE-1:0]  res_q;
  logic                  resv_q;
  logic                  accept, capture, trip, wd_hit;
  logic                  xa_oor, xc_oor;

  assign accept = bus.smp_valid && bus.smp_ready;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    trip    = 1'b0;
    case (state_q)
      IDLE:      if (accept) state_d = WRITE;
      WRITE:     state_d = bus.rbuf_done ? START : WAIT_RBUF;
      WAIT_RBUF: if (bus.rbuf_done) state_d = START;
      START: begin
        if (bus.filt_ready) begin
          if (bus.filt_done) begin
            capture = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.filt_done) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
    // START->RUN is not an exit: the count keeps running into RUN.
    if (wd_hit && !capture && !(state_q == WAIT_RBUF && state_d == START)) begin
      trip    = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      alive_q <= 1'b0;
      di_q    <= '0;
      sel_q   <= '0;
      dc_q    <= 1'b0;
      res_q   <= '0;
      resv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      resv_q  <= capture;
      if (accept) begin
        di_q  <= bus.smp_data;
        sel_q <= bus.filt_sel;
        dc_q  <= bus.dc_en;
      end
      if (capture) res_q <= bus.filt_result;
    end
  end

`ifdef FILT_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;

  assign wd_hit = (state_q inside {WAIT_RBUF, START, RUN}) &&
                  (cnt_q == CW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state_d == WAIT_RBUF && state_q != WAIT_RBUF) ||
          (state_d == START && state_q != START))
        cnt_q <= '0;
      else if (state_q inside {WAIT_RBUF, START, RUN})
        cnt_q <= cnt_q + 1'b1;
      if (trip) err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  // Watchdog compiled out: never trips, waits are unbounded.
  assign wd_hit  = (WDOG_CYCLES < 0);
  assign bus.err = 1'b0;
`endif

  assign bus.smp_ready    = alive_q && (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.rbuf_start   = (state_q == WRITE);
  assign bus.filt_start   = (state_q == START);
  assign bus.rbuf_di      = di_q;
  assign bus.filt_dcValEn = dc_q;
  assign bus.res_valid    = resv_q;
  assign bus.res_data     = res_q;

  // History BRAM: rbuf owns the port while the sample is being written.
  assign xa_oor = (bus.filt_xant_addr > ADDR_SIZE'(M - 1));
  always_comb begin
    bus.xant_en   = bus.filt_xant_ce;
    bus.xant_we   = 1'b0;
    bus.xant_din  = '0;
    bus.xant_addr = xa_oor ? '0 : bus.filt_xant_addr;
    if (state_q == WRITE || state_q == WAIT_RBUF) begin
      bus.xant_en   = bus.rbuf_en;
      bus.xant_we   = bus.rbuf_we;
      bus.xant_din  = bus.rbuf_do;
      bus.xant_addr = bus.rbuf_addr;
    end
  end

  // Out-of-range tap index zeroes the whole address, bank bits included.
  assign xc_oor        = (bus.filt_xcoefs_addr > ADDR_SIZE'(M - 1));
  assign bus.coef_addr = xc_oor ? '0 : {sel_q, bus.filt_xcoefs_addr};
  assign bus.coef_en   = bus.filt_xcoefs_ce && (state_q == START || state_q == RUN);

endmodule

// File: doc/filt_seq_ctrl.md
Name: filt_seq_ctrl

Overview:
- Sequences one sample through the ring buffer and FIR filter: accepts a sample, triggers the ring-buffer write, then launches the filter and captures its result.
- Owns the shared sample-history BRAM port, granting it to the ring buffer during the write phase and to the filter during the compute phase.
- Forms the coefficient BRAM address from the latched filter-select bank.
- Sits between the sample source (ADC/decimator path) and the rbuf / bram_xant / bram_coefs / fir_filter group.

Parameters:
- M, 23: taps + 1; valid xant/coef address range is 0..M-1.
- ADDR_SIZE, 5: filter/rbuf address width.
- DATA_SIZE, 16: sample and result width.
- SEL_SIZE, 2: coefficient-bank select width; coef address is SEL_SIZE+ADDR_SIZE bits.
- WDOG_CYCLES, 1024: watchdog limit; used only with FILT_WDOG_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- smp_valid  in  1  sample offered.
- smp_data  in  DATA_SIZE  sample value.
- smp_ready  out  1  controller can accept a sample.
- filt_sel  in  SEL_SIZE  coefficient bank; latched on sample accept.
- dc_en  in  1  DC-value enable; latched on sample accept.
- rbuf_start  out  1  ring-buffer write trigger.
- rbuf_di  out  DATA_SIZE  sample to ring buffer.
- rbuf_addr  in  ADDR_SIZE  ring-buffer BRAM address.
- rbuf_en  in  1  ring-buffer BRAM enable.
- rbuf_we  in  1  ring-buffer BRAM write enable.
- rbuf_do  in  DATA_SIZE  ring-buffer BRAM write data.
- rbuf_done  in  1  ring-buffer write complete.
- filt_start  out  1  ap_start.
- filt_ready  in  1  ap_ready.
- filt_done  in  1  ap_done.
- filt_result  in  DATA_SIZE  ap_return.
- filt_dcValEn  out  1  latched dc_en.
- filt_xant_addr  in  ADDR_SIZE  filter history address.
- filt_xant_ce  in  1  filter history enable.
- filt_xcoefs_addr  in  ADDR_SIZE  filter coefficient address.
- filt_xcoefs_ce  in  1  filter coefficient enable.
- xant_en  out  1  history BRAM enable.
- xant_we  out  1  history BRAM write enable.
- xant_addr  out  ADDR_SIZE  history BRAM address.
- xant_din  out  DATA_SIZE  history BRAM write data.
- coef_en  out  1  coefficient BRAM enable.
- coef_addr  out  SEL_SIZE+ADDR_SIZE  coefficient BRAM address.
- res_valid  out  1  one-cycle result strobe.
- res_data  out  DATA_SIZE  last captured result; held until the next result.
- busy  out  1  state != IDLE.
- err  out  1  sticky watchdog error.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; every registered output 0, including res_data, err and filt_dcValEn. While in reset, smp_ready=0 and busy=0.
- FSM states: IDLE, WRITE, WAIT_RBUF, START, RUN.
- IDLE:
  - smp_ready=1.
  - On smp_valid&smp_ready: latch smp_data into rbuf_di, filt_sel into sel_q and dc_en into filt_dcValEn, then go to WRITE.
- WRITE: rbuf_start=1 for exactly this one cycle, then go to WAIT_RBUF. If rbuf_done is already high in WRITE, go directly to START.
- WAIT_RBUF: wait for rbuf_done=1, then go to START.
- START:
  - filt_start=1, held until filt_ready is sampled 1.
  - If filt_ready=1 in the same cycle filt_done=1, capture the result and go to IDLE.
  - Otherwise go to RUN when filt_ready=1.
- RUN:
  - filt_start=0.
  - On filt_done=1: res_data<=filt_result, res_valid=1 for the next cycle, go to IDLE.
- Latency: sample accept to res_valid = 1 + rbuf latency + filter latency + 1 cycles.
- History BRAM mux (combinational):
  - In WRITE/WAIT_RBUF: xant_addr=rbuf_addr, xant_en=rbuf_en, xant_we=rbuf_we, xant_din=rbuf_do.
  - Otherwise: xant_we=0, xant_en=filt_xant_ce, xant_din=0, and xant_addr=filt_xant_addr, forced to 0 when filt_xant_addr > M-1.
- Coefficient address:
  - coef_addr={sel_q, filt_xcoefs_addr}; the whole address is forced to 0 when filt_xcoefs_addr > M-1.
  - coef_en=filt_xcoefs_ce, only in START/RUN; otherwise 0.
- Ignored events:
  - smp_valid while busy: sample not accepted; the source must hold it.
  - rbuf_done outside WRITE/WAIT_RBUF.
  - filt_done outside START/RUN.
- Input changes mid-operation: changes on filt_sel/dc_en after accept have no effect until the next accept.
- Reset mid-operation: immediate return to IDLE, with no res_valid.

Optional Feature:
- FILT_WDOG_EN defined:
  - A cycle counter clears on entry to WAIT_RBUF or START and runs through WAIT_RBUF, START and RUN.
  - If the counter reaches WDOG_CYCLES before the exit condition: err<=1 (sticky until reset), filt_start<=0, return to IDLE, no res_valid.
- FILT_WDOG_EN undefined: no counter; the controller waits indefinitely and err is tied to 0.

Test Plan:
- Reset with rst_n=0 mid-RUN -> all outputs 0 asynchronously; smp_ready=1 on the first clk edge after release.
- Single sample 0x0100, filt_sel=2, stub rbuf_done 3 cycles after rbuf_start, stub filter filt_ready on its 1st cycle and filt_done after 30 cycles returning 0x1234 -> rbuf_start exactly 1 cycle; filt_start high until filt_ready; coef_addr upper bits=2'b10; res_data=0x1234 with a 1-cycle res_valid.
- Address clamp: filter drives xant/xcoef address 23 or 31 -> xant_addr=0 and coef_addr=0; address 22 with sel=1 -> coef_addr=7'b0110110.
- Back-to-back: 50 samples offered continuously -> exactly 50 res_valid pulses, in order; smp_ready=0 during every busy window; no sample lost or duplicated.
- Spurious strobes: filt_done in IDLE, rbuf_done in RUN, and filt_sel change during RUN -> no state change, and the result uses the originally latched bank.
- With FILT_WDOG_EN and WDOG_CYCLES=16: filt_done never asserted -> err=1 at cycle 16 of the wait, return to IDLE, no res_valid; the next sample completes normally with err still 1.
